// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one R-bit period counter.
// Counter advances on `enable` ticks; duty (and mode) are double-buffered and
// reloaded only at period boundaries so outputs never glitch mid-period.
// Optional center-aligned mode is built when PWM_MULTI_CENTER_EN is defined;
// otherwise the block is left-aligned only and no up/down logic exists.
//
// Handshake: there is no valid/ready pair here. `enable` is a plain count
// qualifier sampled every clk, and `period_start` is a one-clk strobe that
// is asserted on the same edge that loads the shadow registers.
module pwm_multi #(
    parameter int R        = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*(R+1)-1:0] duty_cycle,
`ifdef PWM_MULTI_CENTER_EN
    input  logic                      center_mode,
`endif
    output logic [CHANNELS-1:0]       q,
    output logic                      period_start
);

    localparam logic [R-1:0] CNT_MAX   = '1;
    localparam logic [R-1:0] CNT_ZERO  = '0;
    localparam logic [R:0]   DUTY_FULL = {1'b1, {R{1'b0}}};

    // Shared period counter and its next value.
    logic [R-1:0]  cnt;
    logic [R-1:0]  cnt_nxt;
    logic          boundary;

    // Shadow duty registers and the saturated live inputs that feed them.
    logic [R:0]    duty_sh  [CHANNELS];
    logic [R:0]    duty_sat [CHANNELS];
    logic [CHANNELS-1:0] q_nxt;

`ifdef PWM_MULTI_CENTER_EN
    // Count direction is the only state machine in the block.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t dir;
    dir_t dir_nxt;
    logic mode_sh;
`endif

    // Clamp each channel's duty so values above 2^R load as exactly 2^R.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            duty_sat[k] = duty_cycle[k*(R+1) +: (R+1)];
            if (duty_cycle[k*(R+1) +: (R+1)] > DUTY_FULL) begin
                duty_sat[k] = DUTY_FULL;
            end
        end
    end

`ifdef PWM_MULTI_CENTER_EN
    // Next counter/direction and boundary detection, using the active mode's rule.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (enable) begin
            if (!mode_sh) begin
                dir_nxt = DIR_UP;
                if (cnt == CNT_MAX) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (dir == DIR_UP) begin
                // The top count is held for one extra tick while turning round.
                if (cnt == CNT_MAX) begin
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                // The second visit to zero is the period boundary.
                if (cnt == CNT_ZERO) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            if (boundary) begin
                cnt_nxt = CNT_ZERO;
                dir_nxt = DIR_UP;
            end
        end
    end
`else
    // Next counter value and boundary detection for the left-aligned-only build.
    always_comb begin
        cnt_nxt  = cnt;
        boundary = 1'b0;
        if (enable) begin
            if (cnt == CNT_MAX) begin
                boundary = 1'b1;
                cnt_nxt  = CNT_ZERO;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end
`endif

    // Per-channel compare of the current count against the shadow duty.
    always_comb begin
        q_nxt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            q_nxt[k] = ({1'b0, cnt} < duty_sh[k]);
        end
    end

    // Counter, shadow registers, outputs; reset wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= CNT_ZERO;
            q            <= '0;
            period_start <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                duty_sh[k] <= '0;
            end
`ifdef PWM_MULTI_CENTER_EN
            dir          <= DIR_UP;
            mode_sh      <= 1'b0;
`endif
        end else begin
            cnt          <= cnt_nxt;
            q            <= q_nxt;
            period_start <= boundary;
`ifdef PWM_MULTI_CENTER_EN
            dir          <= dir_nxt;
`endif
            if (boundary) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    duty_sh[k] <= duty_sat[k];
                end
`ifdef PWM_MULTI_CENTER_EN
                mode_sh <= center_mode;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi (R=8, CHANNELS=4).
// Enable ticks once every 16 clks unless tie_high is set.
module tb_pwm_multi;

  localparam int R  = 8;
  localparam int CH = 4;
  localparam int DW = CH * (R + 1);

  logic          tb_local_clock;
  logic          reset;
  logic          enable;
  logic [DW-1:0] duty_cycle;
  logic          center_mode;
  logic [CH-1:0] q;
  logic          period_start;

  int n_assert = 0;
  int n_fail   = 0;
  int phase    = 0;
  logic tie_high = 1'b0;

  int len;
  int hi      [CH];
  int hi_half [CH];
  logic [CH-1:0] q_first;
  logic [CH-1:0] q_last;
  int wait_clks;
  int q_seen;

  pwm_multi #(.R(R), .CHANNELS(CH)) dut (
    .clk          (tb_local_clock),
    .reset        (reset),
    .enable       (enable),
    .duty_cycle   (duty_cycle),
`ifdef PWM_MULTI_CENTER_EN
    .center_mode  (center_mode),
`endif
    .q            (q),
    .period_start (period_start)
  );

  // clock/reset block
  initial tb_local_clock = 1'b0;
  always #5 tb_local_clock = ~tb_local_clock;

  function automatic logic [DW-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
    logic [8:0] a, b, c, d;
    a = d0[8:0];
    b = d1[8:0];
    c = d2[8:0];
    d = d3[8:0];
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk: drive enable, take the edge, sample 1 time unit later.
  task automatic clk_cycle();
    enable = tie_high || (phase == 15);
    @(posedge tb_local_clock);
    #1;
    phase = (phase + 1) % 16;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_cycle();
    clk_cycle();
    reset = 1'b0;
    phase = 0;
  endtask

  // Run until period_start; counts clks and any q activity on the way.
  task automatic wait_period_start();
    wait_clks = 0;
    q_seen    = 0;
    while (1) begin
      clk_cycle();
      wait_clks++;
      if (q != '0) q_seen = 1;
      if (period_start) break;
      if (wait_clks >= 20000) begin
        chk("wait_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Start right after a period_start sample; measure one full period window.
  task automatic measure_period(input int half, input int change_at,
                                input logic [DW-1:0] new_duty, input logic new_mode);
    len = 0;
    for (int k = 0; k < CH; k++) begin
      hi[k]      = 0;
      hi_half[k] = 0;
    end
    while (1) begin
      if (change_at > 0 && len == change_at) begin
        duty_cycle  = new_duty;
        center_mode = new_mode;
      end
      clk_cycle();
      len++;
      if (len == 1) q_first = q;
      for (int k = 0; k < CH; k++) begin
        if (q[k]) hi[k]++;
        if (q[k] && len <= half) hi_half[k]++;
      end
      if (period_start) break;
      if (len >= 20000) break;
    end
    q_last = q;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    center_mode = 1'b0;
    duty_cycle  = pack4(0, 1, 128, 256);

    // S1: reset, then left mode with duty {0,1,128,256}
    do_reset();
    chk("reset_q", int'(q), 0);
    chk("reset_pstart", int'(period_start), 0);
    wait_period_start();
    chk("first_boundary_clks", wait_clks, 4096);
    chk("first_period_low", q_seen, 0);
    measure_period(0, 0, '0, 1'b0);
    chk("s1_len", len, 4096);
    chk("s1_hi0", hi[0], 0);
    chk("s1_hi1", hi[1], 16);
    chk("s1_hi2", hi[2], 2048);
    chk("s1_hi3", hi[3], 4096);
    chk("s1_qfirst", int'(q_first), 4'b1110);
    chk("s1_qlast", int'(q_last), 4'b1000);

    // S2: duty 64, changed to 200 mid-period
    duty_cycle = pack4(64, 64, 64, 64);
    measure_period(0, 0, '0, 1'b0);
    chk("s2_len_a", len, 4096);
    measure_period(0, 2048, pack4(200, 200, 200, 200), 1'b0);
    chk("s2_hi_old", hi[0], 1024);
    chk("s2_hi_old3", hi[3], 1024);
    measure_period(0, 0, '0, 1'b0);
    chk("s2_hi_new", hi[0], 3200);
    chk("s2_qfirst_new", int'(q_first), 4'b1111);

    // S3: reset mid-period with duty 128
    duty_cycle = pack4(128, 128, 128, 128);
    measure_period(0, 0, '0, 1'b0);
    for (int i = 0; i < 1000; i++) clk_cycle();
    chk("s3_q_before_reset", int'(q), 4'b1111);
    reset = 1'b1;
    clk_cycle();
    chk("s3_reset_q", int'(q), 0);
    chk("s3_reset_pstart", int'(period_start), 0);
    chk("s3_reset_cnt", int'(dut.cnt), 0);
    reset = 1'b0;
    phase = 0;
    wait_period_start();
    chk("s3_boundary_clks", wait_clks, 4096);
    chk("s3_period_low", q_seen, 0);
    measure_period(0, 0, '0, 1'b0);
    chk("s3_len", len, 4096);
    chk("s3_hi2", hi[2], 2048);

    // S4: enable tied high, duty 255/256/300
    tie_high   = 1'b1;
    duty_cycle = pack4(255, 255, 256, 300);
    measure_period(0, 0, '0, 1'b0);
    chk("s4_len_a", len, 256);
    chk("s4_hi_a", hi[0], 128);
    measure_period(0, 0, '0, 1'b0);
    chk("s4_len", len, 256);
    chk("s4_hi0", hi[0], 255);
    chk("s4_hi1", hi[1], 255);
    chk("s4_hi2", hi[2], 256);
    chk("s4_hi3_sat", hi[3], 256);
    tie_high = 1'b0;
    phase    = 0;

`ifdef PWM_MULTI_CENTER_EN
    // S5: left -> center mid-period, duty 64, then back to left
    measure_period(0, 2048, pack4(64, 64, 64, 64), 1'b1);
    chk("s5_left_len", len, 4096);
    measure_period(4096, 0, '0, 1'b0);
    chk("s5_center_len", len, 8192);
    chk("s5_center_hi", hi[0], 2048);
    chk("s5_center_hi_half", hi_half[0], 1024);
    chk("s5_center_qfirst", int'(q_first), 4'b1111);
    chk("s5_center_qlast", int'(q_last), 4'b1111);
    measure_period(0, 4096, pack4(64, 64, 64, 64), 1'b0);
    chk("s5_center_len2", len, 8192);
    measure_period(0, 0, '0, 1'b0);
    chk("s5_back_left_len", len, 4096);
    chk("s5_back_left_hi", hi[0], 1024);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator, parametrised successor to the single-channel left-aligned PWM. CHANNELS independent duty-cycle inputs share one R-bit period counter advanced by an external `enable` tick. Supports left-aligned and (optionally) center-aligned modes. Duty and mode are double-buffered and take effect only at period boundaries, so outputs never glitch mid-period. Sits between a register/control block and the pin drivers; `period_start` lets software or DMA update duty values synchronously.

## Interface
- `R`, 8, counter resolution in bits; M = 2^R − 1 is the maximum count.
- `CHANNELS`, 4, number of PWM outputs.
- `clk` input 1 — the single clock.
- `reset` input 1 — one clock; reset is synchronous and active-high.
- `enable` input 1 — count tick; the counter advances only on `clk` edges where `enable`=1.
- `duty_cycle` input CHANNELS*(R+1) — channel k duty at bits [k*(R+1) +: R+1]; range 0..2^R. Values above 2^R behave as 2^R.
- `center_mode` input 1 — 0 selects left-aligned, 1 selects center-aligned. Present only with `PWM_MULTI_CENTER_EN`.
- `q` output CHANNELS — registered PWM outputs.
- `period_start` output 1 — one-`clk` pulse marking that a new period begins with freshly loaded shadow values.

## Operation
- State: `cnt` [R-1:0], `dir` (up/down), `duty_sh[k]` [R:0], `mode_sh`.
- Left mode (`mode_sh`=0): `cnt` runs 0,1,…,M,0,… Period = 2^R ticks. `dir` is held at up.
- Center mode (`mode_sh`=1): `cnt` runs up 0..M, repeats M once with `dir` flipping to down, runs down M−1..0, then repeats 0 once with `dir` flipping to up. Each endpoint therefore occurs twice. Period = 2^(R+1) ticks.
- Compare: `q[k]` is the registered value of (`cnt` < `duty_sh[k]`).
  - Left mode: high time = duty ticks, starting at the period start.
  - Center mode: high time = 2·duty ticks, centered on the counter minimum, i.e. the period boundary.
  - Duty 0 keeps the output low at all times. Duty ≥ 2^R keeps it high for the whole period, with no single-tick dropout.
- Period boundary: an `enable` tick with left mode and `cnt`=M, or with center mode, `dir`=down and `cnt`=0 (the second 0). On that edge:
  - `cnt` ← 0 and `dir` ← up.
  - `duty_sh[k]` ← `duty_cycle[k]` for all k.
  - `mode_sh` ← `center_mode`.
  - `period_start` ← 1 for exactly one `clk`.
- Inputs change freely between boundaries. Mid-period changes have no effect until the next boundary.
- A mode change takes effect only at a boundary. It is evaluated with the old mode's boundary rule.

## Timing
- Reset values: `cnt`=0, `dir`=up, `duty_sh`=0, `mode_sh`=0, `q`=0, `period_start`=0.
- Reset takes priority over `enable`. Asserting reset mid-period forces the reset values on the next edge.
- The first period after reset runs with duty 0, so `q` stays low. The first real duty is loaded at the first boundary, which is M+1 ticks after reset release.
- Latency: `q` reflects the `cnt` value with one `clk` of delay. `period_start` rises on the same edge that loads the shadow registers. The first `q` of the new period follows one `clk` later.
- `enable` held at 1 continuously is legal: one count per `clk`.
- `enable` gaps stall `cnt`. `q` holds its value during the gap.

## Configuration
- `PWM_MULTI_CENTER_EN` defined:
  - The `center_mode` port, `dir` and `mode_sh` exist.
  - Both modes are supported as described above.
- Not defined:
  - `center_mode` is absent and `mode_sh` is tied to 0.
  - The block is left-aligned only, with period 2^R ticks. No up/down logic is synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use R=8, CHANNELS=4, and `enable` asserted one `clk` in every 16.
- Reset, then duty {0,1,128,256} in left mode. After the first boundary, per 256-tick period: ch0 is never high; ch1 is high for 1 tick; ch2 is high for 128 ticks; ch3 is always high. `period_start` pulses once every 4096 clks.
- Duty 64, `center_mode`=1, after the boundary: period is 512 ticks, `q` is high for 128 ticks, and the high time splits as 64 ticks after the boundary plus 64 ticks before the next boundary.
- Duty changes from 64 to 200 at mid-period: the current period still shows 64 high ticks. The next period shows 200, beginning the `clk` after `period_start`.
- Reset asserted mid-period with duty 128: the next edge gives `q`=0, `cnt`=0 and `period_start`=0. The following period is all-low, then 128 high ticks resume.
- `enable` tied high with duty 255 (left mode): `q` is low for exactly 1 `clk` per 256-clk period. Duty 300 behaves as duty 256, always high.
- Mode switched from left to center at mid-period: the left period completes at 256 ticks, then a 512-tick center period follows. Build without `PWM_MULTI_CENTER_EN`: the left-mode scenarios pass unchanged.
